// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - shared encodings and position clamp for the fighter controller
package fighter_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FWD     = 4'd1,
        ST_BACK    = 4'd2,
        ST_B_START = 4'd3,
        ST_B_ACT   = 4'd4,
        ST_B_REC   = 4'd5,
        ST_D_START = 4'd6,
        ST_D_ACT   = 4'd7,
        ST_D_REC   = 4'd8,
        ST_HSTUN   = 4'd9,
        ST_BSTUN   = 4'd10
    } fighter_state_e;

    localparam logic [1:0] HIT_BASIC = 2'b01;
    localparam logic [1:0] HIT_DIR   = 2'b10;

    // Signed candidate position limited to the legal stage range; never wraps.
    function automatic logic [9:0] clamp_x(input logic signed [10:0] x,
                                           input logic [9:0] lo,
                                           input logic [9:0] hi);
        logic signed [10:0] lo_s;
        logic signed [10:0] hi_s;
        lo_s = signed'({1'b0, lo});
        hi_s = signed'({1'b0, hi});
        if (x < lo_s) begin
            return lo;
        end
        if (x > hi_s) begin
            return hi;
        end
        return x[9:0];
    endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - per-state saturating frame counter with terminal compare
module frame_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [4:0] dur,
    output logic [4:0] count,
    output logic       done
);
    logic [4:0] count_q;
    logic [4:0] count_d;

    // Clear on a state change, otherwise count frames up to 31 and stick there
    always_comb begin
        count_d = count_q;
        if (en) begin
            if (clr) begin
                count_d = 5'd0;
            end else if (count_q != 5'd31) begin
                count_d = count_q + 5'd1;
            end
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= 5'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Last frame of a timed state of length dur
    assign done  = (count_q == dur - 5'd1);
    assign count = count_q;

endmodule

// File: rtl/fighter_fsm.sv
// rtl/fighter_fsm.sv - per-player movement/attack/stun controller
module fighter_fsm
    import fighter_pkg::*;
#(
    parameter int SIDE       = 0,
    parameter int X_INIT     = 100,
    parameter int X_MIN      = 10,
    parameter int X_MAX      = 517,
    parameter int SPD_FWD    = 3,
    parameter int SPD_BACK   = 2,
    parameter int B_STARTUP  = 5,
    parameter int B_ACTIVE   = 2,
    parameter int B_RECOV    = 16,
    parameter int D_STARTUP  = 4,
    parameter int D_ACTIVE   = 3,
    parameter int D_RECOV    = 15,
    parameter int HSTUN_B    = 15,
    parameter int HSTUN_D    = 14,
    parameter int BSTUN_B    = 13,
    parameter int BSTUN_D    = 12,
    parameter int KNOCKBACK  = 8,
    parameter int BLOCK_PUSH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       left,
    input  logic       right,
    input  logic       attack,
    input  logic [1:0] hit_flag,
    input  logic [2:0] block_cnt,
    output logic [9:0] posx,
    output logic [3:0] state,
    output logic [4:0] state_frames,
    output logic       atk_active,
    output logic       atk_kind,
    output logic       block_used,
    output logic       got_hit
);
    // Signed per-frame displacements, mirrored by SIDE
    localparam logic signed [10:0] STEP_FWD   = 11'(SIDE == 0 ? SPD_FWD : -SPD_FWD);
    localparam logic signed [10:0] STEP_BACK  = 11'(SIDE == 0 ? -SPD_BACK : SPD_BACK);
    localparam logic signed [10:0] STEP_KNOCK = 11'(SIDE == 0 ? -KNOCKBACK : KNOCKBACK);
    localparam logic signed [10:0] STEP_PUSH  = 11'(SIDE == 0 ? -BLOCK_PUSH : BLOCK_PUSH);
    localparam logic [9:0]         LO         = 10'(X_MIN);
    localparam logic [9:0]         HI         = 10'(X_MAX);

    fighter_state_e     state_q, state_d, dir_state;
    logic [9:0]         posx_q, posx_d;
    logic [4:0]         stun_len_q, stun_len_d, dur;
    logic               got_hit_q, got_hit_d, block_used_q, block_used_d;
    logic               fwd_in, back_in, hit_any, hittable, phase_done;
    logic signed [10:0] pos_s;

    assign pos_s   = signed'({1'b0, posx_q});
    assign back_in = (SIDE == 0) ? left : right;
    assign fwd_in  = ((SIDE == 0) ? right : left) & ~(left & right);

    // Length of the current timed state; stuns use the length latched on entry
    always_comb begin
        dur = 5'd0;
        case (state_q)
            ST_B_START:         dur = 5'(B_STARTUP);
            ST_B_ACT:           dur = 5'(B_ACTIVE);
            ST_B_REC:           dur = 5'(B_RECOV);
            ST_D_START:         dur = 5'(D_STARTUP);
            ST_D_ACT:           dur = 5'(D_ACTIVE);
            ST_D_REC:           dur = 5'(D_RECOV);
            ST_HSTUN, ST_BSTUN: dur = stun_len_q;
            default:            dur = 5'd0;
        endcase
    end

    // Next state, position and pulses; hits take priority over free choice
    always_comb begin
        state_d      = state_q;
        posx_d       = posx_q;
        stun_len_d   = stun_len_q;
        got_hit_d    = 1'b0;
        block_used_d = 1'b0;
        dir_state    = fwd_in ? ST_FWD : (back_in ? ST_BACK : ST_IDLE);
        hit_any      = (hit_flag == HIT_BASIC) || (hit_flag == HIT_DIR);
        hittable     = state_q inside {ST_IDLE, ST_FWD, ST_BACK, ST_B_START, ST_B_ACT,
                                       ST_B_REC, ST_D_START, ST_D_ACT, ST_D_REC};
        if (frame_tick) begin
            if (hit_any && hittable) begin
                if (state_q == ST_BACK && block_cnt != 3'd0) begin
                    state_d      = ST_BSTUN;
                    stun_len_d   = (hit_flag == HIT_DIR) ? 5'(BSTUN_D) : 5'(BSTUN_B);
                    posx_d       = clamp_x(pos_s + STEP_PUSH, LO, HI);
                    block_used_d = 1'b1;
                end else begin
                    state_d    = ST_HSTUN;
                    stun_len_d = (hit_flag == HIT_DIR) ? 5'(HSTUN_D) : 5'(HSTUN_B);
                    posx_d     = clamp_x(pos_s + STEP_KNOCK, LO, HI);
                    got_hit_d  = 1'b1;
                end
            end else begin
                case (state_q)
                    ST_IDLE: state_d = attack ? ST_B_START : dir_state;
                    ST_FWD: begin
                        state_d = attack ? ST_D_START : dir_state;
                        posx_d  = clamp_x(pos_s + STEP_FWD, LO, HI);
                    end
                    ST_BACK: begin
                        state_d = attack ? ST_D_START : dir_state;
                        posx_d  = clamp_x(pos_s + STEP_BACK, LO, HI);
                    end
                    ST_B_START: if (phase_done) state_d = ST_B_ACT;
                    ST_B_ACT:   if (phase_done) state_d = ST_B_REC;
                    ST_D_START: if (phase_done) state_d = ST_D_ACT;
                    ST_D_ACT:   if (phase_done) state_d = ST_D_REC;
                    ST_B_REC, ST_D_REC, ST_HSTUN, ST_BSTUN:
                        if (phase_done) state_d = attack ? ST_B_START : dir_state;
                    default:    state_d = ST_IDLE;
                endcase
            end
        end
    end

    // State, position, latched stun length and registered pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            posx_q       <= 10'(X_INIT);
            stun_len_q   <= 5'd0;
            got_hit_q    <= 1'b0;
            block_used_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            posx_q       <= posx_d;
            stun_len_q   <= stun_len_d;
            got_hit_q    <= got_hit_d;
            block_used_q <= block_used_d;
        end
    end

    frame_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .en    (frame_tick),
        .clr   (state_d != state_q),
        .dur   (dur),
        .count (state_frames),
        .done  (phase_done)
    );

    assign posx       = posx_q;
    assign state      = state_q;
    assign atk_active = (state_q == ST_B_ACT) || (state_q == ST_D_ACT);
    assign atk_kind   = (state_q == ST_D_ACT);
    assign got_hit    = got_hit_q;
    assign block_used = block_used_q;

endmodule
